// File: rtl/laser_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : laser_ctrl_pkg                                               |
// | Description : Shared types and helpers for the laser firing sequencer:     |
// |               one-hot FSM state enum, default sizing constants and the     |
// |               zero-to-one phase-length clamp.                              |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package laser_ctrl_pkg;

   localparam int LASER_CH_NUM_DEF = 4;
   localparam int LASER_CNT_W_DEF  = 8;

   typedef enum logic [6:0] {
      ST_IDLE   = 7'b000_0001,
      ST_WAIT   = 7'b000_0010,
      ST_RSTI   = 7'b000_0100,
      ST_EMIT   = 7'b000_1000,
      ST_WINDOW = 7'b001_0000,
      ST_NEXT   = 7'b010_0000,
      ST_END    = 7'b100_0000
   } laser_state_e;

   // A programmed length of zero still occupies one cycle.
   function automatic logic [31:0] clamp_len(input logic [31:0] len);
      return (len == 32'd0) ? 32'd1 : len;
   endfunction

endpackage
`default_nettype wire

// File: rtl/laser_ch_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : laser_ch_pick                                                |
// | Description : Combinational finder for the lowest set mask bit strictly    |
// |               above a given channel index (or the lowest set bit overall   |
// |               when searching from the start of the mask).                  |
// | Revision    : 1.0  initial release                                         |
// | Ports       : i_mask       channel mask to search                          |
// |               i_from_start 1 = search from index -1 (whole mask)           |
// |               i_from_idx   search strictly above this index                |
// |               o_found      a qualifying bit exists                         |
// |               o_idx        index of that bit (0 when none)                 |
// +----------------------------------------------------------------------------+
module laser_ch_pick
   import laser_ctrl_pkg::*;
#(
   parameter int CH_NUM = LASER_CH_NUM_DEF,
   parameter int CH_W   = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
   input  logic [CH_NUM-1:0] i_mask,
   input  logic              i_from_start,
   input  logic [CH_W-1:0]   i_from_idx,
   output logic              o_found,
   output logic [CH_W-1:0]   o_idx
);

   // Scan from the top down so the lowest qualifying bit is the last written.
   always_comb begin
      o_found = 1'b0;
      o_idx   = '0;
      for (int i = CH_NUM - 1; i >= 0; i--) begin
         if (i_mask[i] && (i_from_start || (i > int'(i_from_idx)))) begin
            o_found = 1'b1;
            o_idx   = CH_W'(i);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/laser_fire_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : laser_fire_seq                                               |
// | Description : Multi-channel laser firing sequencer for the TDC ranging     |
// |               front end (50 MHz domain). Each angle sync starts a frame    |
// |               that fires every enabled channel in ascending order, each    |
// |               with a TDC index-reset phase, an emit pulse and a receive    |
// |               window, gating the TDC around them.                          |
// | Revision    : 1.0  initial release                                         |
// | Options     : LASER_SYNC_QUEUE_EN - hold one sync arriving mid-frame and   |
// |               start the next frame from it; otherwise it is dropped.       |
// | Ports       : i_clk_50m, i_rst_n (async, active-low)                       |
// |               i_angle_sync  frame start strobe (level)                     |
// |               i_ch_mask     enabled channels                               |
// |               i_rsti_len, i_tdc_arm, i_emit_len, i_window_len, i_stop_cnt  |
// |                             phase lengths / TDC gate points, per frame     |
// |               o_laser_str   per-channel fire strobe                        |
// |               o_disable_tdc, o_rstidx_tdc  TDC control                     |
// |               o_ch_idx, o_busy, o_frame_done, o_sync_miss  status          |
// +----------------------------------------------------------------------------+
module laser_fire_seq
   import laser_ctrl_pkg::*;
#(
   parameter int CH_NUM = LASER_CH_NUM_DEF,
   parameter int CNT_W  = LASER_CNT_W_DEF,
   parameter int CH_W   = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
   input  logic              i_clk_50m,
   input  logic              i_rst_n,
   input  logic              i_angle_sync,
   input  logic [CH_NUM-1:0] i_ch_mask,
   input  logic [CNT_W-1:0]  i_rsti_len,
   input  logic [CNT_W-1:0]  i_tdc_arm,
   input  logic [CNT_W-1:0]  i_emit_len,
   input  logic [CNT_W-1:0]  i_window_len,
   input  logic [CNT_W-1:0]  i_stop_cnt,
   output logic [CH_NUM-1:0] o_laser_str,
   output logic              o_disable_tdc,
   output logic              o_rstidx_tdc,
   output logic [CH_W-1:0]   o_ch_idx,
   output logic              o_busy,
   output logic              o_frame_done,
   output logic              o_sync_miss
);

   localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

   laser_state_e      state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CH_NUM-1:0] mask_q, mask_d;
   logic [CNT_W-1:0]  rsti_len_q, rsti_len_d;
   logic [CNT_W-1:0]  arm_q, arm_d;
   logic [CNT_W-1:0]  emit_len_q, emit_len_d;
   logic [CNT_W-1:0]  win_len_q, win_len_d;
   logic [CNT_W-1:0]  stop_q, stop_d;
   logic              pend_q, pend_d;
   logic [CH_NUM-1:0] laser_str_q, laser_str_d;
   logic              disable_q, disable_d;
   logic              rstidx_q, rstidx_d;
   logic [CH_W-1:0]   ch_idx_q, ch_idx_d;
   logic              busy_q, busy_d;
   logic              frame_done_q, frame_done_d;
   logic              sync_miss_q, sync_miss_d;

   logic              w_start;
   logic              w_pick_at_start;
   logic [CH_NUM-1:0] w_pick_mask;
   logic              w_pick_found;
   logic [CH_W-1:0]   w_pick_idx;
   logic              w_timed;

   // One finder serves both uses: in WAIT it scans the live mask from the
   // bottom, afterwards it scans the latched mask above the current channel.
   assign w_pick_at_start = (state_q == ST_WAIT);
   assign w_pick_mask     = w_pick_at_start ? i_ch_mask : mask_q;

   laser_ch_pick #(
      .CH_NUM (CH_NUM),
      .CH_W   (CH_W)
   ) u_ch_pick (
      .i_mask       (w_pick_mask),
      .i_from_start (w_pick_at_start),
      .i_from_idx   (ch_idx_q),
      .o_found      (w_pick_found),
      .o_idx        (w_pick_idx)
   );

`ifdef LASER_SYNC_QUEUE_EN
   assign w_start = i_angle_sync | pend_q;
`else
   assign w_start = i_angle_sync;
`endif

   assign w_timed = (state_q == ST_RSTI) || (state_q == ST_EMIT) || (state_q == ST_WINDOW);

   always_comb begin
      state_d     = state_q;
      mask_d      = mask_q;
      rsti_len_d  = rsti_len_q;
      arm_d       = arm_q;
      emit_len_d  = emit_len_q;
      win_len_d   = win_len_q;
      stop_d      = stop_q;
      pend_d      = pend_q;
      ch_idx_d    = ch_idx_q;
      disable_d   = disable_q;
      laser_str_d = '0;
      rstidx_d    = 1'b0;
      sync_miss_d = 1'b0;

      case (state_q)
         ST_IDLE: state_d = ST_WAIT;
         ST_WAIT: begin
            pend_d = 1'b0;
            if (w_start) begin
               if (|i_ch_mask) begin
                  mask_d     = i_ch_mask;
                  rsti_len_d = CNT_W'(clamp_len(32'(i_rsti_len)));
                  arm_d      = i_tdc_arm;
                  emit_len_d = CNT_W'(clamp_len(32'(i_emit_len)));
                  win_len_d  = CNT_W'(clamp_len(32'(i_window_len)));
                  stop_d     = i_stop_cnt;
                  ch_idx_d   = w_pick_idx;
                  state_d    = ST_RSTI;
               end else begin
                  sync_miss_d = 1'b1;
               end
            end
         end
         ST_RSTI: begin
            rstidx_d = 1'b1;
            if (cnt_q == arm_q) disable_d = 1'b0;
            if (cnt_q == rsti_len_q - c_one) state_d = ST_EMIT;
         end
         ST_EMIT: begin
            laser_str_d[ch_idx_q] = 1'b1;
            if (cnt_q == emit_len_q - c_one) state_d = ST_WINDOW;
         end
         ST_WINDOW: begin
            // A stop point past the window end is caught on the last window
            // cycle, so the TDC is disabled as NEXT is entered.
            if ((cnt_q == stop_q) || (cnt_q == win_len_q - c_one)) disable_d = 1'b1;
            if (cnt_q == win_len_q - c_one) state_d = ST_NEXT;
         end
         ST_NEXT: begin
            if (w_pick_found) begin
               ch_idx_d = w_pick_idx;
               state_d  = ST_RSTI;
            end else begin
               state_d  = ST_END;
            end
         end
         ST_END:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      if ((state_q != ST_WAIT) && i_angle_sync) begin
`ifdef LASER_SYNC_QUEUE_EN
         if (pend_q) sync_miss_d = 1'b1;
         else        pend_d      = 1'b1;
`else
         sync_miss_d = 1'b1;
`endif
      end

      // Phase counter restarts on every state change.
      cnt_d = (w_timed && (state_d == state_q)) ? cnt_q + c_one : '0;

      busy_d       = (state_d == ST_RSTI) || (state_d == ST_EMIT) || (state_d == ST_WINDOW) ||
                     (state_d == ST_NEXT) || (state_d == ST_END);
      frame_done_d = (state_d == ST_END);
   end

   always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         mask_q       <= '0;
         rsti_len_q   <= c_one;
         arm_q        <= '0;
         emit_len_q   <= c_one;
         win_len_q    <= c_one;
         stop_q       <= '0;
         pend_q       <= 1'b0;
         laser_str_q  <= '0;
         disable_q    <= 1'b1;
         rstidx_q     <= 1'b0;
         ch_idx_q     <= '0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         sync_miss_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         mask_q       <= mask_d;
         rsti_len_q   <= rsti_len_d;
         arm_q        <= arm_d;
         emit_len_q   <= emit_len_d;
         win_len_q    <= win_len_d;
         stop_q       <= stop_d;
         pend_q       <= pend_d;
         laser_str_q  <= laser_str_d;
         disable_q    <= disable_d;
         rstidx_q     <= rstidx_d;
         ch_idx_q     <= ch_idx_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
         sync_miss_q  <= sync_miss_d;
      end
   end

   assign o_laser_str   = laser_str_q;
   assign o_disable_tdc = disable_q;
   assign o_rstidx_tdc  = rstidx_q;
   assign o_ch_idx      = ch_idx_q;
   assign o_busy        = busy_q;
   assign o_frame_done  = frame_done_q;
   assign o_sync_miss   = sync_miss_q;

endmodule
`default_nettype wire

// File: tb/tb_laser_fire_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_laser_fire_seq                                            |
// | Description : Self-checking bench for laser_fire_seq: table of single      |
// |               frame vectors, hand-written multi-cycle sequences and a      |
// |               randomized run against a timeline reference model.           |
// |               Honours LASER_SYNC_QUEUE_EN for its expectations.            |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_laser_fire_seq;

   localparam int CH_NUM = 4;
   localparam int CNT_W  = 8;
   localparam int CH_W   = 2;
   localparam int AS     = 8192;
   localparam int RN     = 6000;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              sync = 1'b0;
   logic [CH_NUM-1:0] mask = '0;
   logic [CNT_W-1:0]  rl = '0, arm = '0, el = '0, wl = '0, stop = '0;
   logic [CH_NUM-1:0] laser_str;
   logic              dis_tdc, rstidx, busy, fdone, smiss;
   logic [CH_W-1:0]   ch_idx;

   int n_cmp = 0;
   int n_bad = 0;

   always #10 clk = ~clk;

   laser_fire_seq #(.CH_NUM(CH_NUM), .CNT_W(CNT_W), .CH_W(CH_W)) dut (
      .i_clk_50m    (clk),
      .i_rst_n      (rst_n),
      .i_angle_sync (sync),
      .i_ch_mask    (mask),
      .i_rsti_len   (rl),
      .i_tdc_arm    (arm),
      .i_emit_len   (el),
      .i_window_len (wl),
      .i_stop_cnt   (stop),
      .o_laser_str  (laser_str),
      .o_disable_tdc(dis_tdc),
      .o_rstidx_tdc (rstidx),
      .o_ch_idx     (ch_idx),
      .o_busy       (busy),
      .o_frame_done (fdone),
      .o_sync_miss  (smiss)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      sync  = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic apply(input logic [3:0] m, input int a, input int b, input int c,
                        input int d, input int e);
      mask = m; rl = 8'(a); arm = 8'(b); el = 8'(c); wl = 8'(d); stop = 8'(e);
   endtask

   // Single-frame vectors: inputs, then hand-derived expected totals.
   typedef struct {
      logic [3:0] m;
      int         rl, arm, el, wl, stop;
      int         busy, rst, las;
      logic [3:0] sor, first, last;
      int         dis_low, fd_at, miss, ch_end;
   } vec_t;
   vec_t tbl[6];

   // Reference timeline for the randomized run, indexed by cycle.
   logic [3:0] e_str [AS];
   bit         e_rst [AS];
   bit         e_busy[AS];
   bit         e_fd  [AS];
   bit         e_miss[AS];
   bit         e_dis [AS];
   int         e_ch  [AS];
   int         wait_from;
   bit         pend;

   // Lay out one frame whose first RSTI cycle is n, from the channel order
   // and the clamped phase lengths.
   task automatic plan_frame(input int n, input logic [3:0] m, input int lr, input int arm_v,
                             input int le, input int lw, input int stop_v);
      int slot, k, b, lo_end;
      slot = lr + le + lw + 1;
      k    = 0;
      for (int c = 0; c < CH_NUM; c++) begin
         if (m[c]) begin
            b = n + k * slot;
            for (int i = b; i < b + slot; i++) if (i < AS) e_ch[i] = c;
            for (int i = b + 1; i <= b + lr; i++) if (i < AS) e_rst[i] = 1'b1;
            for (int i = b + lr + 1; i <= b + lr + le; i++) if (i < AS) e_str[i] = 4'(1 << c);
            if (arm_v < lr) begin
               lo_end = b + lr + le + ((stop_v < lw) ? stop_v : lw - 1);
               for (int i = b + arm_v + 1; i <= lo_end; i++) if (i < AS) e_dis[i] = 1'b0;
            end
            k++;
         end
      end
      for (int i = n; i <= n + k * slot; i++) if (i < AS) e_busy[i] = 1'b1;
      if (n + k * slot < AS) e_fd[n + k * slot] = 1'b1;
      wait_from = n + k * slot + 2;
   endtask

   initial begin
      int   busy_n, rst_c, las_n, dis_n, fd_at, miss_n, fd_n, fd1, fd2, cur_ch;
      int   a_rl, a_arm, a_el, a_wl, a_stop;
      logic [3:0] sor, first, last, a_m;
      bit   got, a_sync, st;

      tbl[0] = '{4'b0001, 16, 6, 3, 100, 40, 121, 16, 3, 4'b0001, 4'b0001, 4'b0001, 53, 120, 0, 0};
      tbl[1] = '{4'b1010,  4, 1, 2,   5,  3,  25,  8, 4, 4'b1010, 4'b0010, 4'b1000, 16,  24, 0, 3};
      tbl[2] = '{4'b0000,  5, 1, 2,   3,  1,   0,  0, 0, 4'b0000, 4'b0000, 4'b0000,  0,  -1, 1, 0};
      tbl[3] = '{4'b0100,  2, 0, 1, 100, 200, 105, 2, 1, 4'b0100, 4'b0100, 4'b0100, 102, 104, 0, 2};
      tbl[4] = '{4'b1000,  5, 5, 2,   3,  1,  12,  5, 2, 4'b1000, 4'b1000, 4'b1000,  0,  11, 0, 3};
      tbl[5] = '{4'b1111,  0, 0, 0,   0,  0,  17,  4, 4, 4'b1111, 4'b0001, 4'b1000,  8,  16, 0, 3};

      // Reset values
      repeat (2) @(negedge clk);
      chk("reset laser_str", 32'(laser_str), 0);
      chk("reset disable_tdc", 32'(dis_tdc), 1);
      chk("reset rstidx_tdc", 32'(rstidx), 0);
      chk("reset ch_idx", 32'(ch_idx), 0);
      chk("reset busy", 32'(busy), 0);
      chk("reset frame_done", 32'(fdone), 0);
      chk("reset sync_miss", 32'(smiss), 0);

      // Table-driven single frames
      for (int r = 0; r < 6; r++) begin
         busy_n = 0; rst_c = 0; las_n = 0; dis_n = 0; fd_at = -1; miss_n = 0;
         sor = '0; first = '0; last = '0;
         do_reset();
         @(negedge clk);
         apply(tbl[r].m, tbl[r].rl, tbl[r].arm, tbl[r].el, tbl[r].wl, tbl[r].stop);
         sync = 1'b1;
         for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            sync = 1'b0;
            busy_n += int'(busy);
            rst_c  += int'(rstidx);
            miss_n += int'(smiss);
            if (!dis_tdc) dis_n++;
            if (fdone && fd_at < 0) fd_at = i;
            if (laser_str != '0) begin
               if (first == '0) first = laser_str;
               last = laser_str;
               sor |= laser_str;
               las_n++;
            end
         end
         chk($sformatf("vec%0d busy_cycles", r), busy_n, tbl[r].busy);
         chk($sformatf("vec%0d rstidx_cycles", r), rst_c, tbl[r].rst);
         chk($sformatf("vec%0d strobe_cycles", r), las_n, tbl[r].las);
         chk($sformatf("vec%0d strobe_or", r), 32'(sor), 32'(tbl[r].sor));
         chk($sformatf("vec%0d first_strobe", r), 32'(first), 32'(tbl[r].first));
         chk($sformatf("vec%0d last_strobe", r), 32'(last), 32'(tbl[r].last));
         chk($sformatf("vec%0d tdc_enabled_cycles", r), dis_n, tbl[r].dis_low);
         chk($sformatf("vec%0d frame_done_at", r), fd_at, tbl[r].fd_at);
         chk($sformatf("vec%0d sync_miss_count", r), miss_n, tbl[r].miss);
         chk($sformatf("vec%0d ch_idx_end", r), 32'(ch_idx), tbl[r].ch_end);
      end

      // Two extra syncs during a frame (slot = 3+2+3+1 = 9)
      fd_n = 0; miss_n = 0; busy_n = 0;
      do_reset();
      @(negedge clk);
      apply(4'b0001, 3, 1, 2, 3, 1);
      sync = 1'b1;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         sync = (i == 1) || (i == 4);
         fd_n   += int'(fdone);
         miss_n += int'(smiss);
         busy_n += int'(busy);
      end
      sync = 1'b0;
`ifdef LASER_SYNC_QUEUE_EN
      chk("dblsync frame_count", fd_n, 2);
      chk("dblsync miss_count", miss_n, 1);
      chk("dblsync busy_cycles", busy_n, 20);
`else
      chk("dblsync frame_count", fd_n, 1);
      chk("dblsync miss_count", miss_n, 2);
      chk("dblsync busy_cycles", busy_n, 10);
`endif

      // Sync held high: frame period = IDLE + WAIT + 120-cycle slot + END
      fd1 = -1; fd2 = -1;
      do_reset();
      @(negedge clk);
      apply(4'b0001, 16, 6, 3, 100, 40);
      sync = 1'b1;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (fdone) begin
            if (fd1 < 0) fd1 = i;
            else if (fd2 < 0) fd2 = i;
         end
      end
      sync = 1'b0;
      chk("period first_done_at", fd1, 120);
      chk("period frame_to_frame", (fd2 >= 0 && fd1 >= 0) ? fd2 - fd1 : -1, 123);

      // Reset during EMIT, with a sync queued earlier in the frame
      do_reset();
      @(negedge clk);
      apply(4'b0001, 2, 0, 4, 5, 0);
      sync = 1'b1;
      @(negedge clk);
      sync = 1'b0;
      @(negedge clk);
      sync = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         sync = 1'b0;
         if (laser_str != '0) got = 1'b1;
      end
      chk("rstemit strobe_seen", 32'(got), 1);
      rst_n = 1'b0;
      #1;
      chk("rstemit laser_str", 32'(laser_str), 0);
      chk("rstemit disable_tdc", 32'(dis_tdc), 1);
      chk("rstemit rstidx_tdc", 32'(rstidx), 0);
      chk("rstemit busy", 32'(busy), 0);
      @(negedge clk);
      rst_n = 1'b1;
      busy_n = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         busy_n += int'(busy);
      end
      chk("rstemit pending_lost", busy_n, 0);
      sync = 1'b1;
      @(negedge clk);
      sync = 1'b0;
      chk("rstemit restart_busy", 32'(busy), 1);

      // Randomized run against the timeline model
      for (int i = 0; i < AS; i++) begin
         e_str[i] = '0; e_rst[i] = 1'b0; e_busy[i] = 1'b0; e_fd[i] = 1'b0;
         e_miss[i] = 1'b0; e_dis[i] = 1'b1; e_ch[i] = -1;
      end
      do_reset();
      wait_from = 0;
      pend      = 1'b0;
      cur_ch    = 0;
      for (int t = 0; t < RN; t++) begin
         @(negedge clk);
         if (e_ch[t] >= 0) cur_ch = e_ch[t];
         chk("rand laser_str", 32'(laser_str), 32'(e_str[t]));
         chk("rand disable_tdc", 32'(dis_tdc), 32'(e_dis[t]));
         chk("rand rstidx_tdc", 32'(rstidx), 32'(e_rst[t]));
         chk("rand ch_idx", 32'(ch_idx), cur_ch);
         chk("rand busy", 32'(busy), 32'(e_busy[t]));
         chk("rand frame_done", 32'(fdone), 32'(e_fd[t]));
         chk("rand sync_miss", 32'(smiss), 32'(e_miss[t]));

         a_m    = 4'($urandom_range(0, 15));
         a_rl   = $urandom_range(0, 12);
         a_arm  = $urandom_range(0, 14);
         a_el   = $urandom_range(0, 12);
         a_wl   = $urandom_range(0, 12);
         a_stop = $urandom_range(0, 14);
         a_sync = ($urandom_range(0, 15) == 0);
         apply(a_m, a_rl, a_arm, a_el, a_wl, a_stop);
         sync = a_sync;

         if (t >= wait_from) begin
            st   = a_sync || pend;
            pend = 1'b0;
            if (st) begin
               if (a_m != '0)
                  plan_frame(t + 1, a_m, (a_rl == 0) ? 1 : a_rl, a_arm, (a_el == 0) ? 1 : a_el,
                             (a_wl == 0) ? 1 : a_wl, a_stop);
               else
                  e_miss[t + 1] = 1'b1;
            end
         end else if (a_sync) begin
`ifdef LASER_SYNC_QUEUE_EN
            if (pend) e_miss[t + 1] = 1'b1;
            else      pend = 1'b1;
`else
            e_miss[t + 1] = 1'b1;
`endif
         end
      end
      sync = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
